simon_stream_adapter: RTL and testbench
=======================================

Name: simon_stream_adapter

Overview:
- Word-stream front/back end for the Simon 128/256 core (`simon`). Sits directly upstream and downstream of it.
- Packs 32-bit input words, arriving over a valid/ready handshake, into one 128-bit block. Pulses the core's start, then waits for the core's done.
- Captures the 128-bit result and serializes it as 32-bit words over a valid/ready output.
- Keys are wired to the core separately and are outside this block's scope.

Parameters:
- WORD_W, 32, stream word width; BLOCK_W must be an exact multiple of WORD_W.
- BLOCK_W, 128, cipher block width (matches the core's in/out).
- TIMEOUT_CYC, 4096, maximum number of cycles spent in WAIT before abandoning the block.

Ports:
- clk  in  1  system clock, rising edge.
- res_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input word valid.
- s_ready  out  1  input word ready (registered).
- s_data  in  WORD_W  input word.
- s_ctrl  in  1  mode bit; sampled with the first word of each block.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream ready.
- m_data  out  WORD_W  output word.
- core_start  out  1  one-cycle start pulse to the core.
- core_ctrl  out  1  mode bit to the core.
- core_in  out  BLOCK_W  block to the core.
- core_out  in  BLOCK_W  result from the core.
- core_done  in  1  core completion (may be a pulse or a held level).
- busy  out  1  high in START, WAIT and DRAIN.
- timeout_err  out  1  sticky timeout flag.
- err_clr  in  1  synchronous clear for timeout_err.

Behaviour:
- Reset (res_n=0, async) drives the following:
  - State = FILL; word counter = 0; timeout counter = 0.
  - s_ready, m_valid, core_start, core_ctrl, busy, timeout_err = 0.
  - core_in, m_data and the internal result register = 0.
  - done_prev = 1, so that a done level held through reset is never taken as an edge.
- s_ready rises on the first clk edge after res_n deasserts.
- Reset mid-operation: the partial block and result are discarded; there is no output of stale data.
- Transfer rule: a transfer occurs on a rising edge when valid and ready are both high. m_data and m_valid stay stable until accepted.
- Word order: the first word of a block occupies bits [BLOCK_W-1 : BLOCK_W-WORD_W] (MSW first). Output uses the same MSW-first order.
- N = BLOCK_W/WORD_W (4 at defaults).
- FILL:
  - s_ready=1.
  - Each transfer writes the word into core_in at slot `cnt` and increments cnt.
  - On the cnt=0 transfer, s_ctrl is latched into core_ctrl.
  - On the N-th transfer: s_ready drops on that same edge, cnt returns to 0, next state = START.
- START:
  - core_start=1 for exactly one cycle; next state = WAIT; timeout counter = 0.
- WAIT:
  - done_prev is registered core_done.
  - Completion = core_done && !done_prev (rising edge only). A level left high from the previous block is ignored.
  - On completion: core_out is captured into the result register, m_data = MSW, m_valid=1 the next cycle, next state = DRAIN.
  - Otherwise the timeout counter increments. At TIMEOUT_CYC-1 without completion: timeout_err=1, the block is discarded, next state = FILL.
- DRAIN:
  - On each output transfer, m_data advances to the next word.
  - After the N-th transfer: m_valid=0, next state = FILL, s_ready=1 on the same edge.
  - m_ready low stalls indefinitely; there is no timeout in DRAIN.
- Stability:
  - core_in and core_ctrl are constant from START until the next block's first word is accepted.
  - s_ctrl on non-first words is ignored.
- timeout_err:
  - err_clr=1 clears it.
  - If a set and err_clr occur on the same edge, set wins.
- The block never accepts input while START, WAIT or DRAIN is active (no overlap).

Test Plan:
- Basic flow:
  - Stimulus: write 0x00112233, 0x44556677, 0x8899AABB, 0xCCDDEEFF with s_ctrl=1 on the first word.
  - Required: core_in = 0x00112233_44556677_8899AABB_CCDDEEFF, core_ctrl=1, and a single 1-cycle core_start on the cycle after the 4th accept.
  - Then, with the core model returning 0xDEADBEEF_01234567_89ABCDEF_FEEDFACE, m_data emits those four words in order.
- Backpressure:
  - Stimulus: hold m_ready=0 for 10 cycles in DRAIN, then toggle it every other cycle.
  - Required: m_data stays 0xDEADBEEF while stalled; exactly 4 transfers occur; s_ready stays 0 until after the last transfer.
- Held done:
  - Stimulus: the core model holds core_done=1 after block 1; stream block 2.
  - Required: no completion until the model drops done and re-raises it; block 2's output matches the new core_out.
- Timeout:
  - Stimulus: core_done never asserts.
  - Required: after TIMEOUT_CYC cycles in WAIT, timeout_err=1, m_valid never rises, and s_ready=1 the following cycle.
  - Then pulse err_clr and check timeout_err=0.
- Reset mid-operation:
  - Stimulus: assert res_n=0 after 2 input words, and again during DRAIN.
  - Required: all outputs are 0 immediately (async); after release, a full fresh 4-word block produces correct output with no leftover words.
- Ctrl latch:
  - Stimulus: s_ctrl=0 on word 0, 1 on words 1–3.
  - Required: core_ctrl=0 for that block.

Source files
------------

// File: rtl/simon_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : simon_stream_adapter
//  Brief    : 32-bit valid/ready word stream <-> 128-bit Simon core adapter.
//             Packs N words (MSW first) into core_in, pulses core_start,
//             waits for a rising edge of core_done (bounded by TIMEOUT_CYC),
//             then serializes the captured result MSW first on the output.
//  Revision : 1.0  initial release
// ============================================================================
module simon_stream_adapter #(
  parameter int WORD_W      = 32,
  parameter int BLOCK_W     = 128,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               res_n,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [WORD_W-1:0]  s_data,
  input  logic               s_ctrl,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic               core_start,
  output logic               core_ctrl,
  output logic [BLOCK_W-1:0] core_in,
  input  logic [BLOCK_W-1:0] core_out,
  input  logic               core_done,
  output logic               busy,
  output logic               timeout_err,
  input  logic               err_clr
);

  // BLOCK_W is expected to be an exact multiple of WORD_W.
  localparam int N  = BLOCK_W / WORD_W;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_FILL  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               s_ready_q, s_ready_d;
  logic               m_valid_q, m_valid_d;
  logic               core_start_q, core_start_d;
  logic               core_ctrl_q, core_ctrl_d;
  logic               timeout_err_q, timeout_err_d;
  logic [BLOCK_W-1:0] core_in_q, core_in_d;
  logic [BLOCK_W-1:0] res_q, res_d;
  logic [WORD_W-1:0]  m_data_q, m_data_d;
  logic               done_prev_q;

  logic               s_xfer;
  logic               m_xfer;
  logic               done_edge;
  logic               tmo_set;
  logic [CW-1:0]      cnt_inc;
  logic [WORD_W-1:0]  next_word;

  assign s_xfer    = s_valid && s_ready_q;
  assign m_xfer    = m_valid_q && m_ready;
  assign done_edge = core_done && !done_prev_q;
  assign cnt_inc   = cnt_q + CW'(1);

  // Select the result word that follows the one currently presented.
  always_comb begin
    next_word = '0;
    for (int i = 0; i < N; i++) begin
      if (cnt_inc == CW'(i)) next_word = res_q[BLOCK_W-1-i*WORD_W -: WORD_W];
    end
  end

  // Next-state and registered-output decode for the fill/start/wait/drain flow.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    tmo_d        = tmo_q;
    s_ready_d    = s_ready_q;
    m_valid_d    = m_valid_q;
    core_start_d = 1'b0;
    core_ctrl_d  = core_ctrl_q;
    core_in_d    = core_in_q;
    res_d        = res_q;
    m_data_d     = m_data_q;
    tmo_set      = 1'b0;
    case (state_q)
      S_FILL: begin
        s_ready_d = 1'b1;
        if (s_xfer) begin
          for (int i = 0; i < N; i++) begin
            if (cnt_q == CW'(i)) core_in_d[BLOCK_W-1-i*WORD_W -: WORD_W] = s_data;
          end
          if (cnt_q == '0) core_ctrl_d = s_ctrl;
          if (cnt_q == LAST_SLOT) begin
            cnt_d        = '0;
            s_ready_d    = 1'b0;
            core_start_d = 1'b1;
            state_d      = S_START;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      S_START: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done_edge) begin
          res_d     = core_out;
          m_data_d  = core_out[BLOCK_W-1 -: WORD_W];
          m_valid_d = 1'b1;
          cnt_d     = '0;
          state_d   = S_DRAIN;
        end else if (tmo_q == TMO_LAST) begin
          // Abandon the block; the core never answered.
          tmo_set   = 1'b1;
          s_ready_d = 1'b1;
          state_d   = S_FILL;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_DRAIN: begin
        if (m_xfer) begin
          if (cnt_q == LAST_SLOT) begin
            cnt_d     = '0;
            m_valid_d = 1'b0;
            s_ready_d = 1'b1;
            state_d   = S_FILL;
          end else begin
            cnt_d    = cnt_inc;
            m_data_d = next_word;
          end
        end
      end
      default: state_d = S_FILL;
    endcase
    // A new timeout on the same edge as a clear keeps the flag set.
    if (tmo_set)      timeout_err_d = 1'b1;
    else if (err_clr) timeout_err_d = 1'b0;
    else              timeout_err_d = timeout_err_q;
  end

  // State and datapath registers; reset discards any partial block or result.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q       <= S_FILL;
      cnt_q         <= '0;
      tmo_q         <= '0;
      s_ready_q     <= 1'b0;
      m_valid_q     <= 1'b0;
      core_start_q  <= 1'b0;
      core_ctrl_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      core_in_q     <= '0;
      res_q         <= '0;
      m_data_q      <= '0;
      done_prev_q   <= 1'b1;  // a done level held through reset is not an edge
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      tmo_q         <= tmo_d;
      s_ready_q     <= s_ready_d;
      m_valid_q     <= m_valid_d;
      core_start_q  <= core_start_d;
      core_ctrl_q   <= core_ctrl_d;
      timeout_err_q <= timeout_err_d;
      core_in_q     <= core_in_d;
      res_q         <= res_d;
      m_data_q      <= m_data_d;
      done_prev_q   <= core_done;
    end
  end

  assign s_ready     = s_ready_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign core_start  = core_start_q;
  assign core_ctrl   = core_ctrl_q;
  assign core_in     = core_in_q;
  assign busy        = (state_q != S_FILL);
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_stream_adapter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_stream_adapter
//  Brief    : Directed self-checking bench for simon_stream_adapter.
//  Revision : 1.0  initial release
// ============================================================================
module tb_simon_stream_adapter;

  localparam int TMO = 4096;

  localparam logic [127:0] B1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] R1 = 128'hDEADBEEF_01234567_89ABCDEF_FEEDFACE;
  localparam logic [127:0] B2 = 128'h0A0B0C0D_10203040_55667788_99AABBCC;
  localparam logic [127:0] R2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] B3 = 128'hCAFEF00D_0BADC0DE_12345678_9ABCDEF0;
  localparam logic [127:0] B4 = 128'hA5A5A5A5_5A5A5A5A_C3C3C3C3_3C3C3C3C;
  localparam logic [127:0] R4 = 128'h0F0F0F0F_F0F0F0F0_77777777_88888888;
  localparam logic [127:0] B5 = 128'h01020304_05060708_090A0B0C_0D0E0F10;
  localparam logic [127:0] R5 = 128'hFACEB00C_ABAD1DEA_8BADF00D_C001D00D;

  logic         clk, res_n;
  logic         s_valid, s_ready, s_ctrl;
  logic [31:0]  s_data;
  logic         m_valid, m_ready;
  logic [31:0]  m_data;
  logic         core_start, core_ctrl, core_done;
  logic [127:0] core_in, core_out;
  logic         busy, timeout_err, err_clr;

  int n_checks = 0;
  int n_err    = 0;

  simon_stream_adapter #(.WORD_W(32), .BLOCK_W(128), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .res_n(res_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_ctrl(s_ctrl),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .core_start(core_start), .core_ctrl(core_ctrl), .core_in(core_in),
    .core_out(core_out), .core_done(core_done),
    .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic c);
    int k = 0;
    s_valid = 1'b1; s_data = d; s_ctrl = c;
    while (s_ready !== 1'b1 && k < 200) begin tick(); k++; end
    chk("s_ready_for_word", s_ready, 1);
    tick();
    s_valid = 1'b0; s_data = '0; s_ctrl = 1'b0;
  endtask

  // ctrl[i] is driven on s_ctrl with word i
  task automatic send_block(input logic [127:0] blk, input logic [3:0] ctrl);
    for (int i = 0; i < 4; i++) send_word(blk[127-32*i -: 32], ctrl[i]);
  endtask

  task automatic recv_block(input logic [127:0] exp, input string tag);
    int k;
    int extra = 0;
    m_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      k = 0;
      while (m_valid !== 1'b1 && k < 50) begin tick(); k++; end
      chk($sformatf("%s_valid%0d", tag, w), m_valid, 1);
      chk($sformatf("%s_word%0d", tag, w), m_data, exp[127-32*w -: 32]);
      tick();
    end
    chk({tag, "_mvalid_low"}, m_valid, 0);
    chk({tag, "_sready_back"}, s_ready, 1);
    for (int i = 0; i < 4; i++) begin
      if (m_valid === 1'b1) extra++;
      tick();
    end
    chk({tag, "_no_extra_words"}, extra, 0);
    m_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] r1w;
    int xfers, cyc, early, moved, seen, cnt;

    res_n = 1'b0; s_valid = 1'b0; s_data = '0; s_ctrl = 1'b0;
    m_ready = 1'b0; core_done = 1'b0; core_out = '0; err_clr = 1'b0;
    repeat (3) tick();

    // ---- reset state
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_core_start", core_start, 0);
    chk("rst_core_ctrl", core_ctrl, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_core_in", core_in, 0);
    chk("rst_m_data", m_data, 0);
    res_n = 1'b1;
    tick();
    chk("sready_after_release", s_ready, 1);

    // ---- basic flow
    send_block(B1, 4'b0001);
    chk("b1_core_start", core_start, 1);
    chk("b1_s_ready_low", s_ready, 0);
    chk("b1_busy", busy, 1);
    chk("b1_core_in", core_in, B1);
    chk("b1_core_ctrl", core_ctrl, 1);
    tick();
    chk("b1_start_one_cycle", core_start, 0);
    core_out = R1; core_done = 1'b1;   // held high afterwards
    tick();
    chk("b1_m_valid", m_valid, 1);
    chk("b1_first_word", m_data, 32'hDEADBEEF);

    // ---- backpressure
    moved = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (m_data !== 32'hDEADBEEF || m_valid !== 1'b1) moved++;
    end
    chk("bp_stall_stable", moved, 0);
    chk("bp_stall_sready", s_ready, 0);
    r1w = R1; xfers = 0; cyc = 0; early = 0;
    while (xfers < 4 && cyc < 40) begin
      m_ready = (cyc % 2 == 0);
      if (s_ready !== 1'b0) early++;
      if (m_valid === 1'b1 && m_ready) begin
        chk($sformatf("bp_word%0d", xfers), m_data, r1w[127-32*xfers -: 32]);
        xfers++;
      end
      tick();
      cyc++;
    end
    m_ready = 1'b0;
    chk("bp_transfer_count", xfers, 4);
    chk("bp_sready_early", early, 0);
    chk("bp_sready_after", s_ready, 1);
    chk("bp_mvalid_after", m_valid, 0);

    // ---- held done + ctrl latch (ctrl 0 on word 0, 1 on words 1-3)
    send_block(B2, 4'b1110);
    chk("b2_core_in", core_in, B2);
    chk("b2_core_ctrl", core_ctrl, 0);
    core_out = R2;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (m_valid === 1'b1) seen++;
    end
    chk("held_done_ignored", seen, 0);
    chk("held_done_busy", busy, 1);
    core_done = 1'b0; tick();
    core_done = 1'b1; tick();
    chk("b2_complete", m_valid, 1);
    recv_block(R2, "b2");
    core_done = 1'b0;

    // ---- timeout
    send_block(B3, 4'b0000);
    cnt = 0; seen = 0;
    while (timeout_err !== 1'b1 && cnt < TMO + 100) begin
      tick();
      cnt++;
      if (m_valid === 1'b1) seen++;
    end
    chk("tmo_flag", timeout_err, 1);
    chk("tmo_cycles", cnt, TMO + 1);     // START cycle + TMO cycles in WAIT
    chk("tmo_no_mvalid", seen, 0);
    chk("tmo_sready", s_ready, 1);
    chk("tmo_busy", busy, 0);
    tick();
    chk("tmo_sticky", timeout_err, 1);
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    chk("tmo_cleared", timeout_err, 0);

    // ---- reset after two input words
    send_word(B4[127:96], 1'b1);
    send_word(B4[95:64], 1'b0);
    chk("rst1_ctrl_latched", core_ctrl, 1);
    #2 res_n = 1'b0;
    #1;
    chk("rst1_core_in", core_in, 0);
    chk("rst1_core_ctrl", core_ctrl, 0);
    chk("rst1_s_ready", s_ready, 0);
    tick();
    res_n = 1'b1;
    tick();
    chk("rst1_sready_back", s_ready, 1);

    // ---- reset during DRAIN
    send_block(B4, 4'b0000);
    tick();
    core_out = R4; core_done = 1'b1; tick(); core_done = 1'b0;
    chk("b4_m_valid", m_valid, 1);
    m_ready = 1'b1; tick(); m_ready = 1'b0;
    chk("b4_word1", m_data, R4[95:64]);
    #2 res_n = 1'b0;
    #1;
    chk("rst2_m_valid", m_valid, 0);
    chk("rst2_m_data", m_data, 0);
    chk("rst2_busy", busy, 0);
    chk("rst2_core_in", core_in, 0);
    tick();
    res_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (m_valid === 1'b1) seen++;
    end
    chk("rst2_no_stale_output", seen, 0);

    // ---- fresh block after reset
    send_block(B5, 4'b0000);
    chk("b5_core_in", core_in, B5);
    tick();
    core_out = R5; core_done = 1'b1; tick(); core_done = 1'b0;
    recv_block(R5, "b5");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
